// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: issues weight reads per activation beat,
// accumulates saturated products and emits bias-added sum after each vector.
module neuron_mac #(
   parameter int unsigned numWeight    = 3,
   parameter int unsigned addressWidth = 10,
   parameter int unsigned dataWidth    = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic signed [dataWidth-1:0]     myinput,
   input  logic                            myinputValid,
   output logic                            w_ren,
   output logic        [addressWidth-1:0]  w_radd,
   input  logic signed [dataWidth-1:0]     w_data,
   input  logic signed [2*dataWidth-1:0]   bias,
   output logic signed [2*dataWidth-1:0]   out,
   output logic                            outvalid
);

   localparam int unsigned SW = 2 * dataWidth;
   localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

   logic signed [dataWidth-1:0] input_reg;
   logic signed [SW-1:0]        mul;
   logic signed [SW-1:0]        sum;
   logic                        v1, l1, v2, l2, v3;

   // Two's complement add clamped to the signed range on overflow.
   function automatic logic signed [SW-1:0] sat_add(input logic signed [SW-1:0] a,
                                                    input logic signed [SW-1:0] b);
      logic signed [SW-1:0] s;
      s = a + b;
      if (!a[SW-1] && !b[SW-1] && s[SW-1])
         return {1'b0, {(SW-1){1'b1}}};
      else if (a[SW-1] && b[SW-1] && !s[SW-1])
         return {1'b1, {(SW-1){1'b0}}};
      return s;
   endfunction

   assign w_ren = myinputValid;

   // Weight address counter, advances only on sampled beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         w_radd <= '0;
      else if (myinputValid)
         w_radd <= (w_radd == LAST_ADDR) ? '0 : w_radd + addressWidth'(1);
   end

   // Stage 0/1: capture activation, then multiply with the returned weight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         input_reg <= '0;
         v1        <= 1'b0;
         l1        <= 1'b0;
         mul       <= '0;
         v2        <= 1'b0;
         l2        <= 1'b0;
      end else begin
         if (myinputValid)
            input_reg <= myinput;
         v1  <= myinputValid;
         l1  <= myinputValid && (w_radd == LAST_ADDR);
         mul <= SW'(input_reg) * SW'(w_data);
         v2  <= v1;
         l2  <= l1;
      end
   end

   // Stage 2/3: accumulate; on vector end emit result and restart the sum,
   // loading the next vector's first product if it lands in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum      <= '0;
         v3       <= 1'b0;
         out      <= '0;
         outvalid <= 1'b0;
      end else begin
         v3       <= v2 && l2;
         outvalid <= v3;
         if (v3) begin
            out <= sat_add(sum, bias);
            sum <= v2 ? mul : '0;
         end else if (v2) begin
            sum <= sat_add(sum, mul);
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: table of vectors plus back-to-back and
// reset sequences, with a weight-memory model and an output scoreboard.
module tb_neuron_mac;

   localparam int unsigned NW = 3;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic signed [DW-1:0]   myinput;
   logic                   myinputValid;
   logic                   w_ren;
   logic [AW-1:0]          w_radd;
   logic signed [DW-1:0]   w_data = '0;
   logic signed [2*DW-1:0] bias;
   logic signed [2*DW-1:0] out;
   logic                   outvalid;

   always #5 clk = ~clk;

   neuron_mac #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
      .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
      .w_ren(w_ren), .w_radd(w_radd), .w_data(w_data), .bias(bias),
      .out(out), .outvalid(outvalid)
   );

   // Weight memory model: registered read one cycle after w_ren.
   logic signed [DW-1:0] mem [NW];
   always @(posedge clk) if (w_ren) w_data <= mem[w_radd];

   typedef struct {
      logic [31:0] val;
      int          cyc;
   } exp_t;
   exp_t q[$];

   typedef struct {
      logic signed [DW-1:0] w [NW];
      logic signed [DW-1:0] x [NW];
      logic signed [31:0]   b;
      int                   gap;
      logic [31:0]          expv;
   } vec_t;
   vec_t tbl [7];

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int unsigned addr  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Scoreboard: every outvalid pulse must match the oldest expected result and cycle.
   always @(negedge clk) begin
      if (!rst && outvalid) begin
         exp_t e;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_outvalid: got out=%0h want no pulse", out);
         end else begin
            e = q.pop_front();
            check("out", out, e.val);
            check("latency_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic beat(input logic signed [DW-1:0] x, input logic last,
                       input logic [31:0] expv, input int gap);
      @(negedge clk);
      myinput      = x;
      myinputValid = 1'b1;
      #1;
      check("w_ren", 32'(w_ren), 32'd1);
      check("w_radd", 32'(w_radd), addr);
      if (last) q.push_back('{expv, cyc + 4});
      addr = (addr + 1) % NW;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         myinputValid = 1'b0;
         myinput      = '0;
         #1;
         check("gap_w_ren", 32'(w_ren), 32'd0);
         check("gap_w_radd", 32'(w_radd), addr);
      end
   endtask

   task automatic idle_and_drain();
      @(negedge clk);
      myinputValid = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending results want 0", q.size());
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{'{1, 2, 3}, '{4, 5, 6}, 10, 0, 32'd42};
      tbl[1] = '{'{1, 2, 3}, '{4, 5, 6}, 10, 2, 32'd42};
      tbl[2] = '{'{-5, 7, 2}, '{100, -3, 50}, -1000, 1, 32'hFFFFFA73};
      tbl[3] = '{'{32767, 32767, 32767}, '{32767, 32767, 32767}, 0, 0, 32'h7FFFFFFF};
      tbl[4] = '{'{-32768, -32768, -32768}, '{32767, 32767, 32767}, 0, 0, 32'h80000000};
      tbl[5] = '{'{1, 2, 3}, '{4, 5, 6}, 32'h7FFFFFF0, 0, 32'h7FFFFFFF};
      tbl[6] = '{'{1, 1, 1}, '{-1, 0, 0}, 32'h80000000, 0, 32'h80000000};

      rst          = 1'b1;
      myinput      = '0;
      myinputValid = 1'b0;
      bias         = '0;
      mem          = '{1, 2, 3};
      #2;
      check("rst_out", out, 32'd0);
      check("rst_outvalid", 32'(outvalid), 32'd0);
      check("rst_w_radd", 32'(w_radd), 32'd0);
      check("rst_w_ren", 32'(w_ren), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         mem  = tbl[i].w;
         bias = tbl[i].b;
         for (int j = 0; j < NW; j++)
            beat(tbl[i].x[j], j == NW - 1, tbl[i].expv, (j == NW - 1) ? 0 : tbl[i].gap);
         idle_and_drain();
      end

      // Back-to-back vectors: first sum must not leak into the second.
      mem  = '{1, 2, 3};
      bias = '0;
      beat(4, 1'b0, 0, 0);
      beat(5, 1'b0, 0, 0);
      beat(6, 1'b1, 32'd32, 0);
      beat(1, 1'b0, 0, 0);
      beat(1, 1'b0, 0, 0);
      beat(1, 1'b1, 32'd6, 0);
      idle_and_drain();

      // Reset mid-vector: partial vector discarded, address restarts at 0.
      bias = 10;
      beat(4, 1'b0, 0, 0);
      beat(5, 1'b0, 0, 0);
      @(negedge clk);
      myinputValid = 1'b0;
      rst          = 1'b1;
      #1;
      check("midrst_out", out, 32'd0);
      check("midrst_outvalid", 32'(outvalid), 32'd0);
      check("midrst_w_radd", 32'(w_radd), 32'd0);
      addr = 0;
      @(negedge clk);
      rst = 1'b0;
      beat(4, 1'b0, 0, 0);
      beat(5, 1'b0, 0, 0);
      beat(6, 1'b1, 32'd42, 0);
      idle_and_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
